// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multicycle control FSM for a shared datapath. One memory port
//            carries both instructions and data. The FSM decodes the opcode
//            and funct held in the IR and drives every datapath enable and mux
//            select, one step per state. It runs a req/ready handshake with a
//            wait-state timeout and counts retired instructions.
// Ports    : clk, rst_n                 clock, async active-low reset
//            opcode, funct              IR[31:26], IR[5:0]
//            zero                       ALU zero flag (current cycle)
//            mem_ready                  memory completes the access this cycle
//            mem_req, mem_we, iord      memory port control
//            ir_we, mdr_we, pc_we       register load enables
//            pc_src, reg_we, reg_dst,   datapath steering
//            mem_to_reg, alu_src_a,
//            alu_src_b, alu_ctl
//            state_o                    current state (debug)
//            instr_cnt                  retired-instruction count
//            illegal                    1-cycle pulse on unknown opcode/funct
//            bus_err                    sticky memory-timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctl,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             illegal,
  output logic             bus_err
);

  // State encodings
  localparam logic [3:0] c_ST_FETCH    = 4'd0;
  localparam logic [3:0] c_ST_DECODE   = 4'd1;
  localparam logic [3:0] c_ST_EXEC_R   = 4'd2;
  localparam logic [3:0] c_ST_WB_R     = 4'd3;
  localparam logic [3:0] c_ST_EXEC_I   = 4'd4;
  localparam logic [3:0] c_ST_WB_I     = 4'd5;
  localparam logic [3:0] c_ST_MEM_ADDR = 4'd6;
  localparam logic [3:0] c_ST_MEM_RD   = 4'd7;
  localparam logic [3:0] c_ST_WB_MEM   = 4'd8;
  localparam logic [3:0] c_ST_MEM_WR   = 4'd9;
  localparam logic [3:0] c_ST_BRANCH   = 4'd10;
  localparam logic [3:0] c_ST_JUMP     = 4'd11;
  localparam logic [3:0] c_ST_HALT     = 4'd15;

  // Opcodes
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] c_FN_ADD = 6'b100000;
  localparam logic [5:0] c_FN_SUB = 6'b100010;
  localparam logic [5:0] c_FN_AND = 6'b100100;
  localparam logic [5:0] c_FN_OR  = 6'b100101;
  localparam logic [5:0] c_FN_SLT = 6'b101010;
  localparam logic [5:0] c_FN_NOR = 6'b100111;

  // ALU operations
  localparam logic [3:0] c_ALU_AND = 4'b0000;
  localparam logic [3:0] c_ALU_OR  = 4'b0001;
  localparam logic [3:0] c_ALU_ADD = 4'b0010;
  localparam logic [3:0] c_ALU_SUB = 4'b0110;
  localparam logic [3:0] c_ALU_SLT = 4'b0111;
  localparam logic [3:0] c_ALU_NOR = 4'b1100;

  // The wait counter never exceeds TIMEOUT-1: the cycle that would take it
  // to TIMEOUT is the one that raises the error and leaves the state.
  localparam logic [7:0]       c_WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  logic             w_funct_ok;
  logic [3:0]       w_alu_r;
  logic [3:0]       w_alu_i;
  logic             w_op_ok;
  logic             w_waiting;
  logic             w_timeout;
  logic             w_retire;

  // --------------------------------------------------------------------------
  // Instruction field decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_funct_ok = 1'b1;
    w_alu_r    = c_ALU_AND;
    case (funct)
      c_FN_ADD: w_alu_r = c_ALU_ADD;
      c_FN_SUB: w_alu_r = c_ALU_SUB;
      c_FN_AND: w_alu_r = c_ALU_AND;
      c_FN_OR:  w_alu_r = c_ALU_OR;
      c_FN_SLT: w_alu_r = c_ALU_SLT;
      c_FN_NOR: w_alu_r = c_ALU_NOR;
      default:  w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_alu_i = c_ALU_ADD;
    case (opcode)
      c_OP_ANDI: w_alu_i = c_ALU_AND;
      c_OP_ORI:  w_alu_i = c_ALU_OR;
      c_OP_SLTI: w_alu_i = c_ALU_SLT;
      default:   w_alu_i = c_ALU_ADD;
    endcase
  end

  assign w_op_ok = (opcode inside {c_OP_RTYPE, c_OP_ADDI, c_OP_ANDI, c_OP_ORI,
                                   c_OP_SLTI, c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_J});

  // mem_req depends on the state only, so using it here forms no loop.
  assign w_waiting = mem_req & ~mem_ready;
  assign w_timeout = w_waiting & (wait_q == c_WAIT_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= c_ST_FETCH;
      wait_q    <= 8'd0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_FETCH: begin
        if (mem_ready)      state_d = c_ST_DECODE;
        else if (w_timeout) state_d = c_ST_HALT;
      end
      c_ST_DECODE: begin
        case (opcode)
          c_OP_RTYPE:                               state_d = c_ST_EXEC_R;
          c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_SLTI: state_d = c_ST_EXEC_I;
          c_OP_LW, c_OP_SW:                         state_d = c_ST_MEM_ADDR;
          c_OP_BEQ:                                 state_d = c_ST_BRANCH;
          c_OP_J:                                   state_d = c_ST_JUMP;
          default:                                  state_d = c_ST_FETCH;
        endcase
      end
      c_ST_EXEC_R:   state_d = w_funct_ok ? c_ST_WB_R : c_ST_FETCH;
      c_ST_WB_R:     state_d = c_ST_FETCH;
      c_ST_EXEC_I:   state_d = c_ST_WB_I;
      c_ST_WB_I:     state_d = c_ST_FETCH;
      c_ST_MEM_ADDR: state_d = (opcode == c_OP_LW) ? c_ST_MEM_RD : c_ST_MEM_WR;
      c_ST_MEM_RD: begin
        if (mem_ready)      state_d = c_ST_WB_MEM;
        else if (w_timeout) state_d = c_ST_HALT;
      end
      c_ST_WB_MEM:   state_d = c_ST_FETCH;
      c_ST_MEM_WR: begin
        if (mem_ready)      state_d = c_ST_FETCH;
        else if (w_timeout) state_d = c_ST_HALT;
      end
      c_ST_BRANCH:   state_d = c_ST_FETCH;
      c_ST_JUMP:     state_d = c_ST_FETCH;
      c_ST_HALT:     state_d = c_ST_HALT;
      default:       state_d = c_ST_FETCH;
    endcase
  end

  // Only completed instructions retire; illegal exits to FETCH come from
  // DECODE or EXEC_R, which are not in this list.
  assign w_retire = (state_d == c_ST_FETCH) &&
                    (state_q inside {c_ST_WB_R, c_ST_WB_I, c_ST_WB_MEM,
                                     c_ST_MEM_WR, c_ST_BRANCH, c_ST_JUMP});

  always_comb begin
    // Any state change clears the counter, so each memory state starts fresh.
    if (state_d != state_q) wait_d = 8'd0;
    else if (w_waiting)     wait_d = wait_q + 8'd1;
    else                    wait_d = wait_q;
    cnt_d     = w_retire ? (cnt_q + c_CNT_ONE) : cnt_q;
    bus_err_d = bus_err_q | w_timeout;
  end

  // --------------------------------------------------------------------------
  // Output decode (from state; handshake enables qualified by mem_ready)
  // --------------------------------------------------------------------------
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_ctl    = c_ALU_AND;
    illegal    = 1'b0;
    case (state_q)
      c_ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        alu_ctl   = c_ALU_ADD;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      c_ST_DECODE: begin
        alu_src_b = 2'd3;
        alu_ctl   = c_ALU_ADD;
        illegal   = ~w_op_ok;
      end
      c_ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_ctl   = w_alu_r;
        illegal   = ~w_funct_ok;
      end
      c_ST_WB_R: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      c_ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_ctl   = w_alu_i;
      end
      c_ST_WB_I: reg_we = 1'b1;
      c_ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_ctl   = c_ALU_ADD;
      end
      c_ST_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mdr_we  = mem_ready;
      end
      c_ST_WB_MEM: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      c_ST_MEM_WR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
      end
      c_ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctl   = c_ALU_SUB;
        pc_src    = 2'd1;
        pc_we     = zero;
      end
      c_ST_JUMP: begin
        pc_we  = 1'b1;
        pc_src = 2'd2;
      end
      default: ;
    endcase
  end

  assign state_o   = state_q;
  assign instr_cnt = cnt_q;
  assign bus_err   = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Self-checking bench for multicycle_ctrl. Each scenario task
//            drives one instruction per cycle sequence, queues the expected
//            control word for every cycle and compares against the captured
//            DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       mdr_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctl;
    logic       illegal;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_we, mdr_we, pc_we;
  logic [1:0]  pc_src;
  logic        reg_we, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_ctl;
  logic [3:0]  state_o;
  logic [31:0] instr_cnt;
  logic        illegal, bus_err;

  int   total;
  int   bad;
  int   exp_cnt;
  obs_t exp_q[$];
  obs_t act_q[$];

  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl),
    .state_o(state_o), .instr_cnt(instr_cnt), .illegal(illegal),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference control word for a state, written from the state table.
  function automatic obs_t spec_out(input logic [3:0] st, input logic rdy,
                                    input logic z, input logic [5:0] op,
                                    input logic [5:0] fn);
    obs_t o;
    o = '0;
    o.state = st;
    case (st)
      4'd0: begin o.mem_req = 1; o.alu_src_b = 2'd1; o.alu_ctl = 4'b0010;
                  o.ir_we = rdy; o.pc_we = rdy; end
      4'd1: begin o.alu_src_b = 2'd3; o.alu_ctl = 4'b0010;
                  o.illegal = !(op inside {6'b000000, 6'b001000, 6'b001100,
                    6'b001101, 6'b001010, 6'b100011, 6'b101011, 6'b000100,
                    6'b000010}); end
      4'd2: begin
        o.alu_src_a = 1;
        case (fn)
          6'b100000: o.alu_ctl = 4'b0010;
          6'b100010: o.alu_ctl = 4'b0110;
          6'b100100: o.alu_ctl = 4'b0000;
          6'b100101: o.alu_ctl = 4'b0001;
          6'b101010: o.alu_ctl = 4'b0111;
          6'b100111: o.alu_ctl = 4'b1100;
          default:   o.illegal = 1;
        endcase
      end
      4'd3: begin o.reg_we = 1; o.reg_dst = 1; end
      4'd4: begin
        o.alu_src_a = 1; o.alu_src_b = 2'd2;
        case (op)
          6'b001100: o.alu_ctl = 4'b0000;
          6'b001101: o.alu_ctl = 4'b0001;
          6'b001010: o.alu_ctl = 4'b0111;
          default:   o.alu_ctl = 4'b0010;
        endcase
      end
      4'd5: o.reg_we = 1;
      4'd6: begin o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_ctl = 4'b0010; end
      4'd7: begin o.mem_req = 1; o.iord = 1; o.mdr_we = rdy; end
      4'd8: begin o.reg_we = 1; o.mem_to_reg = 1; end
      4'd9: begin o.mem_req = 1; o.iord = 1; o.mem_we = 1; end
      4'd10: begin o.alu_src_a = 1; o.alu_ctl = 4'b0110; o.pc_src = 2'd1;
                   o.pc_we = z; end
      4'd11: begin o.pc_we = 1; o.pc_src = 2'd2; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{state: state_o, mem_req: mem_req, mem_we: mem_we, iord: iord,
          ir_we: ir_we, mdr_we: mdr_we, pc_we: pc_we, pc_src: pc_src,
          reg_we: reg_we, reg_dst: reg_dst, mem_to_reg: mem_to_reg,
          alu_src_a: alu_src_a, alu_src_b: alu_src_b, alu_ctl: alu_ctl,
          illegal: illegal};
    return o;
  endfunction

  // One clock of stimulus: drive, queue expectation, capture mid-cycle.
  task automatic step(input logic [3:0] st, input logic rdy);
    mem_ready = rdy;
    exp_q.push_back(spec_out(st, rdy, zero, opcode, funct));
    @(negedge clk);
    act_q.push_back(sample());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
    #2;
    total++;
    if (state_o !== 4'd0 || instr_cnt !== 32'd0 || bus_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs state=%0d cnt=%0d err=%b want 0/0/0", state_o, instr_cnt, bus_err);
    end
    total++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || ir_we !== 1'b0 || reg_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_outs req=%b we=%b ir_we=%b reg_we=%b want 1/0/0/0", mem_req, mem_we, ir_we, reg_we);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_rtype();
    logic [5:0] fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    for (int i = 0; i < 6; i++) begin
      opcode = 6'b000000; funct = fns[i];
      step(4'd0, 1); step(4'd1, 1); step(4'd2, 1); step(4'd3, 1);
      exp_cnt++;
      total++;
      if (instr_cnt !== 32'(exp_cnt) || state_o !== 4'd0) begin
        bad++;
        $display("FAIL rtype_retire fn=%b cnt=%0d state=%0d want %0d/0", fns[i], instr_cnt, state_o, exp_cnt);
      end
    end
    while (exp_q.size() != 0) begin
      obs_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL rtype_ctl got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_itype();
    logic [5:0] ops [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
    for (int i = 0; i < 4; i++) begin
      opcode = ops[i]; funct = 6'b010101;
      step(4'd0, 1); step(4'd1, 1); step(4'd4, 1); step(4'd5, 1);
      exp_cnt++;
    end
    total++;
    if (instr_cnt !== 32'(exp_cnt)) begin
      bad++; $display("FAIL itype_cnt got=%0d want=%0d", instr_cnt, exp_cnt);
    end
    while (exp_q.size() != 0) begin
      obs_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL itype_ctl got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_lw_wait();
    int cyc;
    opcode = 6'b100011; funct = 6'b000000;
    cyc = 0;
    step(4'd0, 1); step(4'd1, 1); step(4'd6, 1); cyc += 3;
    for (int i = 0; i < 3; i++) begin step(4'd7, 0); cyc++; end
    step(4'd7, 1); step(4'd8, 1); cyc += 2;
    exp_cnt++;
    total++;
    if (cyc != 8 || state_o !== 4'd0 || instr_cnt !== 32'(exp_cnt)) begin
      bad++;
      $display("FAIL lw_latency cyc=%0d state=%0d cnt=%0d want 8/0/%0d", cyc, state_o, instr_cnt, exp_cnt);
    end
    while (exp_q.size() != 0) begin
      obs_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL lw_ctl got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_sw();
    // mem_ready low in non-memory states must be ignored
    opcode = 6'b101011; funct = 6'b000000;
    step(4'd0, 1); step(4'd1, 0); step(4'd6, 0); step(4'd9, 0); step(4'd9, 1);
    exp_cnt++;
    total++;
    if (instr_cnt !== 32'(exp_cnt)) begin
      bad++; $display("FAIL sw_cnt got=%0d want=%0d", instr_cnt, exp_cnt);
    end
    while (exp_q.size() != 0) begin
      obs_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL sw_ctl got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_branch_jump();
    opcode = 6'b000100; funct = 6'b000000;
    zero = 1'b1;
    step(4'd0, 1); step(4'd1, 1); step(4'd10, 1);
    exp_cnt++;
    zero = 1'b0;
    step(4'd0, 1); step(4'd1, 1); step(4'd10, 1);
    exp_cnt++;
    opcode = 6'b000010;
    step(4'd0, 1); step(4'd1, 1); step(4'd11, 1);
    exp_cnt++;
    total++;
    if (instr_cnt !== 32'(exp_cnt)) begin
      bad++; $display("FAIL br_j_cnt got=%0d want=%0d", instr_cnt, exp_cnt);
    end
    while (exp_q.size() != 0) begin
      obs_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL br_j_ctl got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111; funct = 6'b100000;
    step(4'd0, 1); step(4'd1, 1);
    total++;
    if (state_o !== 4'd0 || instr_cnt !== 32'(exp_cnt)) begin
      bad++;
      $display("FAIL illegal_op state=%0d cnt=%0d want 0/%0d", state_o, instr_cnt, exp_cnt);
    end
    opcode = 6'b000000; funct = 6'b000001;
    step(4'd0, 1); step(4'd1, 1); step(4'd2, 1);
    total++;
    if (state_o !== 4'd0 || instr_cnt !== 32'(exp_cnt)) begin
      bad++;
      $display("FAIL illegal_fn state=%0d cnt=%0d want 0/%0d", state_o, instr_cnt, exp_cnt);
    end
    while (exp_q.size() != 0) begin
      obs_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL illegal_ctl got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_timeout_boundary();
    // 15 wait cycles then ready on the 16th: the access completes, no error.
    opcode = 6'b000000; funct = 6'b100000;
    for (int i = 0; i < 15; i++) step(4'd0, 0);
    step(4'd0, 1); step(4'd1, 1); step(4'd2, 1); step(4'd3, 1);
    exp_cnt++;
    total++;
    if (bus_err !== 1'b0 || instr_cnt !== 32'(exp_cnt)) begin
      bad++;
      $display("FAIL tmo_edge err=%b cnt=%0d want 0/%0d", bus_err, instr_cnt, exp_cnt);
    end
    while (exp_q.size() != 0) begin
      obs_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL tmo_edge_ctl got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_reset_mid_write();
    opcode = 6'b101011; funct = 6'b000000;
    step(4'd0, 1); step(4'd1, 1); step(4'd6, 1); step(4'd9, 0); step(4'd9, 0);
    total++;
    if (mem_we !== 1'b1 || state_o !== 4'd9) begin
      bad++; $display("FAIL wr_pending we=%b state=%0d want 1/9", mem_we, state_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (state_o !== 4'd0 || instr_cnt !== 32'd0 || mem_we !== 1'b0 || mem_req !== 1'b1) begin
      bad++;
      $display("FAIL async_rst state=%0d cnt=%0d we=%b req=%b want 0/0/0/1", state_o, instr_cnt, mem_we, mem_req);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt = 0;
    while (exp_q.size() != 0) begin
      obs_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL rst_wr_ctl got=%h want=%h", a, e); end
    end
  endtask

  task automatic test_timeout();
    opcode = 6'b000000; funct = 6'b100000;
    for (int i = 0; i < 16; i++) step(4'd0, 0);
    total++;
    if (bus_err !== 1'b1 || state_o !== 4'd15) begin
      bad++; $display("FAIL timeout err=%b state=%0d want 1/15", bus_err, state_o);
    end
    for (int i = 0; i < 3; i++) step(4'd15, 1);
    total++;
    if (bus_err !== 1'b1 || state_o !== 4'd15 || instr_cnt !== 32'(exp_cnt)) begin
      bad++;
      $display("FAIL halt_hold err=%b state=%0d cnt=%0d want 1/15/%0d", bus_err, state_o, instr_cnt, exp_cnt);
    end
    while (exp_q.size() != 0) begin
      obs_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL halt_ctl got=%h want=%h", a, e); end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus_err !== 1'b0 || state_o !== 4'd0) begin
      bad++; $display("FAIL halt_exit err=%b state=%0d want 0/0", bus_err, state_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_cnt = 0;
    test_reset();
    test_rtype();
    test_itype();
    test_lw_wait();
    test_sw();
    test_branch_jump();
    test_illegal();
    test_timeout_boundary();
    test_reset_mid_write();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
